// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALUOp encodings, control-bit positions and the
// bundle carried from decode to execute.
package riscv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // Positions inside the 6-bit control word {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch}
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef struct packed {
    logic [RV_XLEN-1:0]   pc;
    logic [RV_XLEN-1:0]   rs1_data;
    logic [RV_XLEN-1:0]   rs2_data;
    logic [RV_XLEN-1:0]   imm;
    logic [RV_REG_AW-1:0] rs1;
    logic [RV_REG_AW-1:0] rs2;
    logic [RV_REG_AW-1:0] rd;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [1:0]           aluop;
    logic [5:0]           ctrl;
  } id_ex_bus_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready comes straight from a flop so the upstream path is not combinational.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept, retire;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid & in_ready;
  assign retire    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (retire && skid_valid_q) begin
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      skid_valid_d = accept;
      if (accept) skid_data_d = in_data;
    end else if ((retire || !main_valid_q) && !skid_valid_q) begin
      main_valid_d = accept;
      if (accept) main_data_d = in_data;
    end else if (main_valid_q && !retire && accept) begin
      // EX stalled: park the new instruction, main stays stable
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/id_ex_stage_buf.sv
// ID->EX pipeline buffer: packs decode fields into one bus, buffers it in an
// elastic skid stage and presents a NOP-masked copy to EX.
module id_ex_stage_buf #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [1:0]        out_aluop,
  output logic [5:0]        out_ctrl
);
  import riscv_pkg::*;

  id_ex_bus_t in_bus;
  id_ex_bus_t out_bus;

  assign in_bus = '{pc:       in_pc,
                    rs1_data: in_rs1_data,
                    rs2_data: in_rs2_data,
                    imm:      in_imm,
                    rs1:      in_rs1,
                    rs2:      in_rs2,
                    rd:       in_rd,
                    f3:       in_funct3,
                    f7:       in_funct7,
                    aluop:    in_aluop,
                    ctrl:     in_ctrl};

  pipe_skid_buf #(.W($bits(id_ex_bus_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bus)
  );

  assign out_pc       = out_bus.pc;
  assign out_rs1_data = out_bus.rs1_data;
  assign out_rs2_data = out_bus.rs2_data;
  assign out_imm      = out_bus.imm;
  assign out_rs1      = out_bus.rs1;
  assign out_rs2      = out_bus.rs2;
  assign out_rd       = out_bus.rd;
  assign out_funct3   = out_bus.f3;
  assign out_funct7   = out_bus.f7;

  // Stale data is harmless, but control must read as a NOP when nothing is valid
  assign out_aluop = out_valid ? out_bus.aluop : ALUOP_ADD;
  assign out_ctrl  = out_valid ? out_bus.ctrl  : 6'b0;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Scoreboard bench for id_ex_stage_buf: directed scenarios plus a random
// valid/ready/flush run, all retirements checked against an expected queue.
module tb_id_ex_stage_buf;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  id_ex_bus_t  in_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [1:0]  out_aluop;
  logic [5:0]  out_ctrl;
  id_ex_bus_t  out_b;

  int errors = 0;
  int checks = 0;
  id_ex_bus_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_buf #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_b.pc), .in_rs1_data(in_b.rs1_data), .in_rs2_data(in_b.rs2_data),
    .in_imm(in_b.imm), .in_rs1(in_b.rs1), .in_rs2(in_b.rs2), .in_rd(in_b.rd),
    .in_funct3(in_b.f3), .in_funct7(in_b.f7), .in_aluop(in_b.aluop), .in_ctrl(in_b.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_aluop(out_aluop),
    .out_ctrl(out_ctrl)
  );

  assign out_b = '{pc: out_pc, rs1_data: out_rs1_data, rs2_data: out_rs2_data,
                   imm: out_imm, rs1: out_rs1, rs2: out_rs2, rd: out_rd,
                   f3: out_funct3, f7: out_funct7, aluop: out_aluop, ctrl: out_ctrl};

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic id_ex_bus_t mk(input logic [31:0] pc, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] imm,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [1:0] aluop,
                                    input logic [5:0] ctrl);
    id_ex_bus_t r;
    r = '{pc: pc, rs1_data: a, rs2_data: b, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
          f3: f3, f7: f7, aluop: aluop, ctrl: ctrl};
    return r;
  endfunction

  // Called at posedge+1: apply inputs for the coming edge, record expected
  // acceptance, then move to just after that edge.
  task automatic drive(input logic v, input id_ex_bus_t b, input logic rdy, input logic fl);
    in_valid  = v;
    in_b      = b;
    out_ready = rdy;
    flush     = fl;
    if (rst_n && v && in_ready && !fl) exp_q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will use
  logic       stall_prev = 1'b0;
  logic       flush_prev = 1'b0;
  id_ex_bus_t held_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
      flush_prev = 1'b0;
    end else begin
      if (flush_prev) begin
        chk("flush_out_valid", 192'(out_valid), 192'(1'b0));
        chk("flush_in_ready", 192'(in_ready), 192'(1'b1));
      end
      if (stall_prev) begin
        chk("stall_valid_held", 192'(out_valid), 192'(1'b1));
        chk("stall_fields_held", 192'(out_b), 192'(held_b));
      end
      if (!out_valid) chk("bubble_nop", 192'({out_aluop, out_ctrl}), 192'(0));
      if (flush) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: got pc %0h expected no retire at %0t", out_pc, $time);
        end else begin
          chk("retire_fields", 192'(out_b), 192'(exp_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      flush_prev = flush;
      held_b     = out_b;
    end
  end

  id_ex_bus_t v[4];
  id_ex_bus_t nop_b;
  id_ex_bus_t r;
  logic [31:0] rpc;

  initial begin
    nop_b = '0;
    v[0] = mk(32'h100, 32'd5, 32'd7, 32'h0,        5'd1, 5'd2, 5'd3, 3'd0, 7'h00, ALUOP_RTYPE,  6'b100000);
    v[1] = mk(32'h104, 32'd9, 32'd4, 32'h0,        5'd1, 5'd2, 5'd4, 3'd0, 7'h20, ALUOP_RTYPE,  6'b100000);
    v[2] = mk(32'h108, 32'd9, 32'd0, 32'hffffffff, 5'd1, 5'd0, 5'd5, 3'd0, 7'h7f, ALUOP_ADD,    6'b100010);
    v[3] = mk(32'h10c, 32'd3, 32'd3, 32'h10,       5'd1, 5'd2, 5'd0, 3'd0, 7'h00, ALUOP_BRANCH, 6'b000001);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 192'(out_valid), 192'(1'b0));
    chk("reset_out_ctrl", 192'(out_ctrl), 192'(0));
    chk("reset_out_pc", 192'(out_pc), 192'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 192'(in_ready), 192'(1'b1));

    // Stream at full rate, one cycle latency
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i], 1'b1, 1'b0);
      chk("stream_valid", 192'(out_valid), 192'(1'b1));
      chk("stream_pc", 192'(out_pc), 192'(v[i].pc));
      chk("stream_aluop", 192'(out_aluop), 192'(v[i].aluop));
    end
    drive(1'b0, nop_b, 1'b1, 1'b0);
    chk("bubble_valid", 192'(out_valid), 192'(1'b0));
    chk("bubble_aluop", 192'(out_aluop), 192'(2'b00));
    chk("bubble_regwrite_memwrite", 192'({out_ctrl[CTRL_REGWRITE], out_ctrl[CTRL_MEMWRITE]}), 192'(2'b00));

    // Backpressure: 3 stalled cycles with decode still offering work
    drive(1'b1, mk(32'h200, 1, 2, 3, 1, 2, 3, 3'd1, 7'h01, ALUOP_RTYPE, 6'b100000), 1'b0, 1'b0);
    chk("bp_in_ready_1", 192'(in_ready), 192'(1'b1));
    drive(1'b1, mk(32'h204, 4, 5, 6, 4, 5, 6, 3'd2, 7'h02, ALUOP_ADD, 6'b110110), 1'b0, 1'b0);
    chk("bp_in_ready_2", 192'(in_ready), 192'(1'b0));
    chk("bp_pc_held", 192'(out_pc), 192'(32'h200));
    drive(1'b1, mk(32'h208, 7, 8, 9, 7, 8, 9, 3'd3, 7'h03, ALUOP_ADD, 6'b001010), 1'b0, 1'b0);
    chk("bp_in_ready_3", 192'(in_ready), 192'(1'b0));
    chk("bp_pc_held2", 192'(out_pc), 192'(32'h200));
    drive(1'b1, mk(32'h208, 7, 8, 9, 7, 8, 9, 3'd3, 7'h03, ALUOP_ADD, 6'b001010), 1'b1, 1'b0);
    chk("bp_release_pc", 192'(out_pc), 192'(32'h204));
    chk("bp_release_ready", 192'(in_ready), 192'(1'b1));
    drive(1'b1, mk(32'h208, 7, 8, 9, 7, 8, 9, 3'd3, 7'h03, ALUOP_ADD, 6'b001010), 1'b1, 1'b0);
    chk("bp_third_pc", 192'(out_pc), 192'(32'h208));
    drive(1'b0, nop_b, 1'b1, 1'b0);
    chk("bp_drained", 192'(out_valid), 192'(1'b0));

    // Flush with both entries full, then flush racing an accept
    drive(1'b1, mk(32'h300, 1, 1, 1, 1, 1, 1, 3'd0, 7'h00, ALUOP_RTYPE, 6'b100000), 1'b0, 1'b0);
    drive(1'b1, mk(32'h304, 2, 2, 2, 2, 2, 2, 3'd0, 7'h00, ALUOP_RTYPE, 6'b100000), 1'b0, 1'b0);
    chk("flush_pre_full", 192'(in_ready), 192'(1'b0));
    drive(1'b1, mk(32'h308, 3, 3, 3, 3, 3, 3, 3'd0, 7'h00, ALUOP_RTYPE, 6'b100000), 1'b0, 1'b1);
    chk("flush_valid", 192'(out_valid), 192'(1'b0));
    chk("flush_ctrl", 192'(out_ctrl), 192'(0));
    chk("flush_ready", 192'(in_ready), 192'(1'b1));
    drive(1'b1, mk(32'h30c, 4, 4, 4, 4, 4, 4, 3'd0, 7'h00, ALUOP_RTYPE, 6'b100000), 1'b1, 1'b1);
    chk("flush_accept_discarded", 192'(out_valid), 192'(1'b0));
    drive(1'b1, mk(32'h310, 5, 5, 5, 5, 5, 5, 3'd4, 7'h00, ALUOP_ADD, 6'b110110), 1'b1, 1'b0);
    chk("post_flush_pc", 192'(out_pc), 192'(32'h310));
    drive(1'b0, nop_b, 1'b1, 1'b0);

    // Asynchronous reset with both entries full
    drive(1'b1, mk(32'h400, 6, 6, 6, 6, 6, 6, 3'd0, 7'h00, ALUOP_RTYPE, 6'b100000), 1'b0, 1'b0);
    drive(1'b1, mk(32'h404, 7, 7, 7, 7, 7, 7, 3'd0, 7'h00, ALUOP_RTYPE, 6'b100000), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 192'(out_valid), 192'(1'b0));
    chk("async_rst_ctrl", 192'(out_ctrl), 192'(0));
    chk("async_rst_ready", 192'(in_ready), 192'(1'b1));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, nop_b, 1'b1, 1'b0);
    chk("after_rst_no_output", 192'(out_valid), 192'(1'b0));

    // Random valid/ready/flush
    rpc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      r = mk(rpc, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), 2'($urandom), 6'($urandom));
      drive(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 15) == 0));
      if (in_valid && !flush && exp_q.size() > 0 && exp_q[exp_q.size()-1].pc == rpc)
        rpc = rpc + 32'd4;
    end
    repeat (4) drive(1'b0, nop_b, 1'b1, 1'b0);
    chk("drain_queue_empty", 192'(exp_q.size()), 192'(0));
    chk("drain_out_valid", 192'(out_valid), 192'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
